// File: rtl/div_stream_ctrl.sv
`timescale 1ns/1ps
// div_stream_ctrl: valid/ready issue/collect front end for a fixed-latency pipelined divider.
// Optional build macro DIV_STREAM_DIVZERO_EN adds the out_divzero flag per result.
module div_stream_ctrl #(
  parameter int DATA_LEN    = 32,
  parameter int DIV_LATENCY = 6,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_LEN-1:0]           in_a,
  input  logic [DATA_LEN-1:0]           in_b,
  output logic [DATA_LEN-1:0]           div_a,
  output logic [DATA_LEN-1:0]           div_b,
  input  logic [DATA_LEN-1:0]           div_result,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_LEN-1:0]           out_data,
`ifdef DIV_STREAM_DIVZERO_EN
  output logic                          out_divzero,
`endif
  input  logic                          flush_req,
  output logic                          flush_done,
  output logic [$clog2(FIFO_DEPTH):0]   inflight
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
`ifdef DIV_STREAM_DIVZERO_EN
  localparam int ENTRY_W = DATA_LEN + 1;
`else
  localparam int ENTRY_W = DATA_LEN;
`endif

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_LEN-1:0]  div_a_q, div_a_d;
  logic [DATA_LEN-1:0]  div_b_q, div_b_d;
  logic [DIV_LATENCY:0] tag_q, tag_d;
  logic [CNT_W-1:0]     inflight_q, inflight_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];

  logic                 accept;
  logic                 capture;
  logic                 pop;
  logic [CNT_W:0]       credit_used;
  logic [ENTRY_W-1:0]   wr_entry;
  logic [ENTRY_W-1:0]   head;

  // Credit covers both queued results and ops still inside the divider, so a
  // capture can never find the FIFO full.
  assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};
  assign in_ready    = ~reset & (state_q == ST_RUN) & (credit_used < DEPTH_C);
  assign accept      = in_valid & in_ready;
  // tag_q[0] travels with the div_a/div_b register; stages 1..DIV_LATENCY
  // mirror the divider's own registers, so the last stage flags a valid quotient.
  assign capture     = tag_q[DIV_LATENCY];
  assign out_valid   = (count_q != '0);
  assign pop         = out_valid & out_ready;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    div_a_d    = div_a_q;
    div_b_d    = div_b_q;
    tag_d      = {tag_q[DIV_LATENCY-1:0], accept};
    inflight_d = inflight_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (accept) begin
      div_a_d = in_a;
      div_b_d = in_b;
    end

    if (accept && !capture) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!accept && capture) begin
      inflight_d = inflight_q - CNT_W'(1);
    end

    if (capture && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!capture && pop) begin
      count_d = count_q - CNT_W'(1);
    end

    if (capture) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (flush_req) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((inflight_q == '0) && (count_q == '0)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        flush_done = 1'b1;
        state_d    = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q    <= ST_RUN;
      div_a_q    <= '0;
      div_b_q    <= '0;
      tag_q      <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      div_a_q    <= div_a_d;
      div_b_q    <= div_b_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

`ifdef DIV_STREAM_DIVZERO_EN
  logic [DIV_LATENCY:0] dz_q, dz_d;

  always_comb begin
    dz_d = {dz_q[DIV_LATENCY-1:0], accept & (in_b == '0)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dz_q <= '0;
    end else begin
      dz_q <= dz_d;
    end
  end

  assign wr_entry    = {dz_q[DIV_LATENCY], div_result};
  assign out_divzero = out_valid & head[DATA_LEN];
`else
  assign wr_entry    = div_result;
`endif

  // NOTE: the storage array has no reset; empty entries are never visible because
  // out_data is gated by out_valid, which comes from the reset count.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign head     = mem_q[rd_ptr_q];
  assign out_data = out_valid ? head[DATA_LEN-1:0] : '0;
  assign div_a    = div_a_q;
  assign div_b    = div_b_q;
  assign inflight = inflight_q;

endmodule

// File: tb/tb_div_stream_ctrl.sv
`timescale 1ns/1ps
// tb_div_stream_ctrl: directed stimulus with a result scoreboard for div_stream_ctrl,
// driving a 6-stage behavioural divider on div_a/div_b/div_result.
module tb_div_stream_ctrl;

  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        flush_req = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_ready, out_valid, flush_done;
  logic [31:0] div_a, div_b, div_result, out_data;
  logic [4:0]  inflight;
`ifdef DIV_STREAM_DIVZERO_EN
  logic        out_divzero;
`endif

  div_stream_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_result (div_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
`ifdef DIV_STREAM_DIVZERO_EN
    .out_divzero(out_divzero),
`endif
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .inflight   (inflight)
  );

  always #5 clk = ~clk;

  // Divider model: no reset, six registers from the operand register to div_result.
  logic [31:0] dpipe [LAT];
  logic [31:0] dq;
  always_comb begin
    dq = '0;
    if (div_b != '0) dq = 32'($signed(div_a) / $signed(div_b));
  end
  always @(posedge clk) begin
    dpipe[0] <= dq;
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign div_result = dpipe[LAT-1];

  typedef struct packed {
    logic [31:0] data;
    logic        chk;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_acc = 0;
  int n_pop = 0;
  int n_fd = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  int fd_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over a result.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!reset) begin
      if (flush_done) begin
        n_fd++;
        fd_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        n_pop++;
        last_pop_cyc = cyc + 1;
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: actual=%0h required=none", out_data);
        end else begin
          e = sb.pop_front();
          if (e.chk) check("out_data", {32'd0, out_data}, {32'd0, e.data});
`ifdef DIV_STREAM_DIVZERO_EN
          check("out_divzero", {63'd0, out_divzero}, {63'd0, e.dz});
`endif
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                      input logic chk, input logic dz, input logic fl);
    int w;
    exp_t e;
    @(negedge clk);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    flush_req = fl;
    #1;
    w = 0;
    while (!in_ready && w < 300) begin
      @(negedge clk);
      flush_req = 1'b0;
      #1;
      w++;
    end
    if (in_ready) begin
      e.data = q;
      e.chk  = chk;
      e.dz   = dz;
      sb.push_back(e);
      n_acc++;
    end else begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", w);
    end
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q);
    send(a, b, q, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid  = 1'b0;
    flush_req = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int w;
    w = 0;
    while ((sb.size() != 0 || out_valid) && w < 500) begin
      @(posedge clk);
      #3;
      w++;
    end
    check(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, pop0, fd0, nh, first, last, nbad, spur;

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    check("rst_in_ready",   {63'd0, in_ready},   64'd0);
    check("rst_out_valid",  {63'd0, out_valid},  64'd0);
    check("rst_out_data",   {32'd0, out_data},   64'd0);
    check("rst_div_a",      {32'd0, div_a},      64'd0);
    check("rst_inflight",   {59'd0, inflight},   64'd0);
    check("rst_flush_done", {63'd0, flush_done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #3;
    check("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

    // Single op: quotient visible exactly 7 edges after the accept edge, for one cycle
    out_ready = 1'b1;
    op(32'd100, 32'd7, 32'd14);
    idle();
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #3;
      check($sformatf("lat_out_valid_%0d", k), {63'd0, out_valid}, {63'd0, (k == 7)});
      if (k == 7) check("lat_out_data", {32'd0, out_data}, 64'd14);
    end

    // Signed truncation, back-to-back
    op(-32'sd100, 32'd7, -32'sd14);
    op(32'd100, -32'sd7, -32'sd14);
    op(-32'sd7, 32'd2, -32'sd3);
    idle();
    nh = 0; first = -1; last = -1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #3;
      if (out_valid) begin
        if (first < 0) first = k;
        last = k;
        nh++;
      end
    end
    check("signed_valid_cycles", 64'(nh), 64'd3);
    check("signed_contiguous", 64'(last - first), 64'd2);

    // Backpressure: credit admits exactly FIFO_DEPTH ops
    out_ready = 1'b0;
    acc0 = n_acc;
    pop0 = n_pop;
    fork
      begin
        for (int i = 0; i < 20; i++) op(32'((i + 2) * 7 + 3), 32'd7, 32'(i + 2));
        idle();
      end
      begin
        repeat (40) @(posedge clk);
        #3;
        check("bp_accepted",  64'(n_acc - acc0),   64'd16);
        check("bp_in_ready",  {63'd0, in_ready},   64'd0);
        check("bp_inflight",  {59'd0, inflight},   64'd0);
        check("bp_out_valid", {63'd0, out_valid},  64'd1);
        check("bp_head_held", {32'd0, out_data},   64'd2);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_drain("bp_drain");
    check("bp_results", 64'(n_pop - pop0), 64'd20);

    // Flush with in_valid held: third op shares the flush_req cycle
    fd0  = n_fd;
    acc0 = n_acc;
    op(32'd21, 32'd3, 32'd7);
    op(-32'sd21, 32'd3, -32'sd7);
    send(32'd22, -32'sd5, -32'sd4, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    flush_req = 1'b0;
    in_a = 32'd50;
    in_b = 32'd5;
    nbad = 0;
    for (int k = 0; k < 40; k++) begin
      if (n_fd > fd0) break;
      #1;
      if (in_ready) nbad++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("flush_no_accept",   64'(nbad),          64'd0);
    check("flush_accepts",     64'(n_acc - acc0),  64'd3);
    check("flush_done_count",  64'(n_fd - fd0),    64'd1);
    check("flush_done_timing", 64'(fd_cyc),        64'(last_pop_cyc + 1));
    wait_drain("flush_drain");

    // Idle flush: flush_done two cycles after flush_req
    @(negedge clk);
    flush_req = 1'b1;
    @(posedge clk);
    #3;
    check("idle_flush_done_c1",  {63'd0, flush_done}, 64'd0);
    check("idle_flush_in_ready", {63'd0, in_ready},   64'd0);
    @(negedge clk);
    flush_req = 1'b0;
    @(posedge clk);
    #3;
    check("idle_flush_done_c2", {63'd0, flush_done}, 64'd1);
    @(posedge clk);
    #3;
    check("idle_flush_done_c3",   {63'd0, flush_done}, 64'd0);
    check("idle_flush_ready_c3",  {63'd0, in_ready},   64'd1);

    // Reset mid-operation
    op(32'd1, 32'd1, 32'd1);
    op(32'd2, 32'd1, 32'd2);
    op(32'd3, 32'd1, 32'd3);
    op(32'd4, 32'd1, 32'd4);
    idle();
    @(posedge clk);
    #3;
    check("pre_reset_inflight", {59'd0, inflight}, 64'd4);
    reset = 1'b1;
    #1;
    sb.delete();
    check("mid_rst_out_valid",  {63'd0, out_valid},  64'd0);
    check("mid_rst_out_data",   {32'd0, out_data},   64'd0);
    check("mid_rst_div_a",      {32'd0, div_a},      64'd0);
    check("mid_rst_div_b",      {32'd0, div_b},      64'd0);
    check("mid_rst_inflight",   {59'd0, inflight},   64'd0);
    check("mid_rst_in_ready",   {63'd0, in_ready},   64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #3;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    spur = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) spur++;
      @(posedge clk);
      #3;
    end
    check("post_rst_spurious", 64'(spur), 64'd0);

`ifdef DIV_STREAM_DIVZERO_EN
    // Divide-by-zero flag travels with its result
    send(32'd5, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    send(32'd5, 32'd1, 32'd5, 1'b1, 1'b0, 1'b0);
    idle();
    wait_drain("divzero_drain");
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
